csa3_serial_digit_adder: RTL and testbench

- Digit-serial three-operand adder controller for the multiplier's partial-product reduction path.
- Accepts three WIDTH-bit operands over a valid/ready handshake and feeds one 2-bit digit of each operand per cycle into a 3-input 2-bit digit slice.
- Carries the slice's multi-valued carry (0..2) forward between cycles and reassembles the full (WIDTH+2)-bit sum.
- Presents the sum downstream over a second valid/ready handshake.

---
 rtl/csa3_serial_pkg.sv | 19 +
 rtl/csa3_digit_slice.sv | 24 ++
 rtl/csa3_serial_digit_adder.sv | 117 +++++++++++
 tb/tb_csa3_serial_digit_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa3_serial_pkg.sv
// Shared types and constants for the digit-serial three-operand adder.
// One digit is two bits; the inter-digit carry spans 0..2.
package csa3_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DIGIT_W       = 2;
  localparam int CARRY_W       = 2;
  localparam int MAX_DIGIT_SUM = 11;

  function automatic int digit_count(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/csa3_digit_slice.sv
// Combinational 3-input 2-bit digit slice with a multi-valued carry (0..2).
// Sums three digits plus the incoming carry; largest total is 3+3+3+2 = 11.
module csa3_digit_slice
  import csa3_serial_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic [DIGIT_W-1:0] c,
  input  logic [CARRY_W-1:0] cin,
  output logic [DIGIT_W-1:0] digit,
  output logic [CARRY_W-1:0] cout
);

  localparam int SUM_W = $clog2(MAX_DIGIT_SUM + 1);

  logic [SUM_W-1:0] digit_sum;

  always_comb begin
    digit_sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(cin);
    digit     = digit_sum[DIGIT_W-1:0];
    cout      = digit_sum[SUM_W-1:DIGIT_W];
  end

endmodule

// File: rtl/csa3_serial_digit_adder.sv
// Digit-serial three-operand adder: accepts a triple, walks it two bits per
// cycle through a single digit slice, and hands the exact sum downstream.
module csa3_serial_digit_adder
  import csa3_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum,
  output logic             busy
);

  localparam int N     = digit_count(WIDTH);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [WIDTH-1:0]   op3_q, op3_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CARRY_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH+1:0]   sum_q, sum_d;

  logic [DIGIT_W-1:0] slice_digit;
  logic [CARRY_W-1:0] slice_cout;
  logic [WIDTH+1:0]   result_ext;

  csa3_digit_slice u_slice (
    .a     (op1_q[DIGIT_W-1:0]),
    .b     (op2_q[DIGIT_W-1:0]),
    .c     (op3_q[DIGIT_W-1:0]),
    .cin   (carry_q),
    .digit (slice_digit),
    .cout  (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
      result_q <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
    end
  end

  // New digits enter the result from the MSB end so digit 0 lands at bit 0.
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    op3_d      = op3_q;
    result_d   = result_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    result_ext = {slice_digit, result_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op1_d   = in1;
          op2_d   = in2;
          op3_d   = in3;
          carry_d = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op1_d    = op1_q >> DIGIT_W;
        op2_d    = op2_q >> DIGIT_W;
        op3_d    = op3_q >> DIGIT_W;
        result_d = WIDTH'(result_ext >> DIGIT_W);
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d   = {slice_cout, result_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_csa3_serial_digit_adder.sv
// Bench for csa3_serial_digit_adder: directed triples, an arithmetic
// transaction model checked every cycle, and literal sums for each test.
module tb_csa3_serial_digit_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1, in2, in3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] sum;
  logic             busy;

  logic       in_valid2;
  logic       in_ready2;
  logic [1:0] a2, b2, c2;
  logic       out_valid2;
  logic [3:0] sum2;
  logic       busy2;

  int vectors = 0;
  int miscompares = 0;

  csa3_serial_digit_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  csa3_serial_digit_adder #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in1       (a2),
    .in2       (b2),
    .in3       (c2),
    .out_valid (out_valid2),
    .out_ready (1'b1),
    .sum       (sum2),
    .busy      (busy2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: a triple occupies the block for N digit cycles,
  // then its exact sum waits for the consumer; the last sum stays visible.
  logic             m_busy;
  logic             m_valid;
  int               m_left;
  logic [WIDTH+1:0] m_pending;
  logic [WIDTH+1:0] m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_left = 0; m_pending = '0; m_sum = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy    = 1'b1;
        m_left    = N;
        m_pending = (WIDTH+2)'(in1) + (WIDTH+2)'(in2) + (WIDTH+2)'(in3);
      end
    end else if (m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_sum   = m_pending;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  always @(negedge clk) begin
    checkOutput("model in_ready", 32'(in_ready), 32'(!m_busy));
    checkOutput("model out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("model busy", 32'(busy), 32'(m_busy));
    checkOutput("model sum", 32'(sum), 32'(m_sum));
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c);
    int guard = 0;
    in1 = a; in2 = b; in3 = c; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!out_valid) checkOutput("out_valid timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int gap;
    bit seen;
    in_valid = 1'b0; in1 = '0; in2 = '0; in3 = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; c2 = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=2 instance: one digit, so the sum appears one edge after accept.
    in_valid2 = 1'b1; a2 = 2'd3; b2 = 2'd3; c2 = 2'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    edges = 0;
    while (!out_valid2 && edges < 10) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    checkOutput("w2 edges incl accept", 32'(edges + 1), 32'd2);
    checkOutput("w2 sum", 32'(sum2), 32'h9);
    @(negedge clk);

    applyStimulus(16'h0000, 16'h0000, 16'h0000);
    waitValid(edges);
    checkOutput("zero edges incl accept", 32'(edges + 1), 32'(N + 1));
    checkOutput("zero sum", 32'(sum), 32'h00000);
    @(negedge clk);

    applyStimulus(16'h1234, 16'h5678, 16'h9ABC);
    checkOutput("mix in_ready in run", 32'(in_ready), 32'd0);
    waitValid(edges);
    checkOutput("mix sum", 32'(sum), 32'h10368);
    checkOutput("mix in_ready in done", 32'(in_ready), 32'd0);
    @(negedge clk);

    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int k = 0; k < N; k++) begin
      checkOutput("max slice cout", 32'(dut.u_slice.cout), 32'd2);
      if (k >= 1) checkOutput("max slice cin", 32'(dut.u_slice.cin), 32'd2);
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("max out_valid", 32'(out_valid), 32'd1);
    checkOutput("max sum", 32'(sum), 32'h2FFFD);
    @(negedge clk);

    out_ready = 1'b0;
    applyStimulus(16'h0101, 16'h0202, 16'h0303);
    waitValid(edges);
    in1 = 16'h1111; in2 = 16'h2222; in3 = 16'h3333; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
      checkOutput("bp sum held", 32'(sum), 32'h00606);
      checkOutput("bp no accept", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp handoff out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp idle in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp sum kept", 32'(sum), 32'h00606);

    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort sum", 32'(sum), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) begin
      @(negedge clk);
      checkOutput("abort no out_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(16'h0001, 16'h0002, 16'h0003);
    waitValid(edges);
    checkOutput("post-abort sum", 32'(sum), 32'h00006);
    @(negedge clk);

    // Back-to-back with in_valid and out_ready held high.
    in1 = 16'h0001; in2 = 16'h0001; in3 = 16'h0001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in1 = 16'h8000; in2 = 16'h8000; in3 = 16'h8000;
    gap = 0;
    seen = 1'b0;
    while (!in_ready && gap < 40) begin
      if (out_valid) begin
        seen = 1'b1;
        checkOutput("b2b first sum", 32'(sum), 32'h00003);
      end
      @(posedge clk);
      gap++;
      @(negedge clk);
    end
    checkOutput("b2b first seen", 32'(seen), 32'd1);
    checkOutput("b2b accept spacing", 32'(gap + 1), 32'(N + 2));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waitValid(edges);
    checkOutput("b2b second edges incl accept", 32'(edges + 1), 32'(N + 1));
    checkOutput("b2b second sum", 32'(sum), 32'h18000);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
